// File: rtl/stepper_pkg.sv
// Shared constants for the stepper command reader: command word layout,
// tick counter width and FSM state encoding.
package stepper_pkg;

  // Command word layout
  localparam int unsigned CMD_W   = 32;
  localparam int unsigned DIR_BIT = 31;
  localparam int unsigned CNT_LSB = 0;

  // Half-period tick counter width (covers HALF_PERIOD up to 65535)
  localparam int unsigned TICK_W  = 16;

  // FSM state encoding
  localparam int unsigned STATE_W = 3;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_HIGH = 3'd2;
  localparam logic [2:0] ST_LOW  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Reload value so that a phase lasts exactly half_period cycles
  function automatic logic [TICK_W-1:0] tick_reload(input int unsigned half_period);
    return TICK_W'(half_period - 1);
  endfunction

endpackage

// File: rtl/stepper_tick_counter.sv
// Loadable down-counter timing one step-pulse phase; expire is high while the
// count sits at zero.
module stepper_tick_counter
  import stepper_pkg::*;
#(
  parameter int unsigned W = TICK_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         expire_q;

  // Next count: load wins, otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register with registered expire flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      expire_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= (cnt_d == '0);
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/stepper_cmd_reader.sv
// Consumes a step command from a falling-edge command register and emits
// step/dir pulses to a motor driver, with abort and completion reporting.
module stepper_cmd_reader
  import stepper_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic [CMD_W-1:0]  cmd_word,
  input  logic              cmd_valid,
  input  logic              abort,
  output logic              cmd_ack,
  output logic              step,
  output logic              dir,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  steps_remaining
);

  localparam logic [TICK_W-1:0] TICK_RELOAD = tick_reload(HALF_PERIOD);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  logic [CNT_W-1:0]   rem_q;
  logic [CNT_W-1:0]   rem_d;
  logic               dir_q;
  logic               dir_d;
  logic               aborted_q;
  logic               aborted_d;
  logic               step_q;
  logic               busy_q;
  logic               done_q;
  logic               ack_q;

  logic               tick_load_c;
  logic               tick_expire;

  // Reserved command bits are intentionally ignored
  logic               unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_word;

  // Phase timer shared by the HIGH and LOW phases
  stepper_tick_counter #(
    .W (TICK_W)
  ) u_tick (
    .clk_i      (clock),
    .rst_ni     (ctrl_reset),
    .load_i     (tick_load_c),
    .load_val_i (TICK_RELOAD),
    .expire_o   (tick_expire)
  );

  // Next-state, command capture and phase timer reload decisions
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    dir_d       = dir_q;
    aborted_d   = aborted_q;
    tick_load_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort is ignored here, so a command arriving with abort still starts
        if (cmd_valid) begin
          state_d   = ST_LOAD;
          dir_d     = cmd_word[DIR_BIT];
          rem_d     = cmd_word[CNT_LSB +: CNT_W];
          aborted_d = 1'b0;
        end
      end

      ST_LOAD: begin
        if (abort) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (rem_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d     = ST_HIGH;
          tick_load_c = 1'b1;
        end
      end

      ST_HIGH: begin
        if (abort) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (tick_expire) begin
          state_d     = ST_LOW;
          tick_load_c = 1'b1;
        end
      end

      ST_LOW: begin
        // abort takes priority over step completion so the count holds
        if (abort) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (tick_expire) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_HIGH;
            tick_load_c = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and Moore outputs, registered from the next state
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      rem_q     <= '0;
      dir_q     <= 1'b0;
      aborted_q <= 1'b0;
      step_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      dir_q     <= dir_d;
      aborted_q <= aborted_d;
      step_q    <= (state_d == ST_HIGH);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      ack_q     <= (state_d == ST_LOAD);
    end
  end

  assign cmd_ack         = ack_q;
  assign step            = step_q;
  assign dir             = dir_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign aborted         = aborted_q;
  assign steps_remaining = rem_q;

endmodule

// File: tb/tb_stepper_cmd_reader.sv
// Directed bench for stepper_cmd_reader with HALF_PERIOD=4.
module tb_stepper_cmd_reader;

  localparam int unsigned HP = 4;
  localparam int unsigned CW = 16;

  logic          clock      = 1'b0;
  logic          ctrl_reset = 1'b0;
  logic [31:0]   cmd_word   = 32'h0;
  logic          cmd_valid  = 1'b0;
  logic          abort      = 1'b0;
  logic          cmd_ack;
  logic          step;
  logic          dir;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [CW-1:0] steps_remaining;

  int checks = 0;
  int errors = 0;

  stepper_cmd_reader #(
    .HALF_PERIOD (HP),
    .CNT_W       (CW)
  ) dut (
    .clock           (clock),
    .ctrl_reset      (ctrl_reset),
    .cmd_word        (cmd_word),
    .cmd_valid       (cmd_valid),
    .abort           (abort),
    .cmd_ack         (cmd_ack),
    .step            (step),
    .dir             (dir),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted),
    .steps_remaining (steps_remaining)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] word;
    int          abort_cyc;      // busy cycle during which abort is driven (0 = none)
    bit          abort_acc;      // abort driven together with cmd_valid in IDLE
    int          stray_cyc;      // busy cycle with a stray cmd_valid pulse (0 = none)
    int          exp_busy;
    int          exp_pulses;
    int          exp_first_rise;
    bit          exp_dir;
    bit          exp_aborted;
    int          exp_rem_load;
    int          exp_rem_end;
  } vec_t;

  vec_t vecs[7];

  // Issue one command and check its whole trace against the record
  task automatic run_vec(input vec_t v, input int idx);
    int   acks = 0, ack_cyc = 0, dones = 0, done_cyc = 0;
    int   rises = 0, first_rise = 0, falls = 0;
    int   hi_run = 0, lo_run = 0, bad_hi = 0, bad_lo = 0, dir_bad = 0;
    int   busy_len = 0, rem_load = -1, rem_end = -1;
    logic ab_at_load = 1'b1, ab_at_done = 1'b0, step_at_done = 1'b1;
    logic prev_step = 1'b0;
    bit   in_low = 1'b0;
    string tag;
    tag = $sformatf("v%0d", idx);

    @(negedge clock);
    cmd_word  = v.word;
    cmd_valid = 1'b1;
    abort     = v.abort_acc;

    for (int n = 1; n <= 400; n++) begin
      @(negedge clock);
      if (n == 1) begin
        cmd_valid = 1'b0;
        abort     = 1'b0;
      end
      if (!busy) break;
      busy_len = n;
      if (cmd_ack) begin
        acks++;
        if (acks == 1) ack_cyc = n;
      end
      if (n == 1) begin
        rem_load   = int'(steps_remaining);
        ab_at_load = aborted;
      end
      if (dir !== v.exp_dir) dir_bad++;
      if (step && !prev_step) begin
        rises++;
        if (first_rise == 0) first_rise = n;
        if (in_low && lo_run != HP) bad_lo++;
        in_low = 1'b0;
        hi_run = 0;
      end
      if (step) hi_run++;
      if (!step && prev_step) begin
        falls++;
        if (hi_run != HP && !(v.exp_aborted && falls == v.exp_pulses)) bad_hi++;
        in_low = 1'b1;
        lo_run = 0;
      end
      if (!step && in_low) lo_run++;
      if (done) begin
        dones++;
        done_cyc     = n;
        ab_at_done   = aborted;
        step_at_done = step;
        rem_end      = int'(steps_remaining);
      end
      prev_step = step;
      if (v.abort_cyc != 0 && n == v.abort_cyc) abort = 1'b1;
      if (v.abort_cyc != 0 && n == v.abort_cyc + 1) abort = 1'b0;
      if (v.stray_cyc != 0 && n == v.stray_cyc) begin
        cmd_valid = 1'b1;
        cmd_word  = 32'h0000_0009;
      end
      if (v.stray_cyc != 0 && n == v.stray_cyc + 1) cmd_valid = 1'b0;
    end
    abort     = 1'b0;
    cmd_valid = 1'b0;

    chk({tag, " busy_len"},   busy_len,     v.exp_busy);
    chk({tag, " ack_count"},  acks,         1);
    chk({tag, " ack_cycle"},  ack_cyc,      1);
    chk({tag, " pulses"},     rises,        v.exp_pulses);
    chk({tag, " first_rise"}, first_rise,   v.exp_first_rise);
    chk({tag, " bad_high"},   bad_hi,       0);
    chk({tag, " bad_low"},    bad_lo,       0);
    chk({tag, " dir_bad"},    dir_bad,      0);
    chk({tag, " done_count"}, dones,        1);
    chk({tag, " done_cycle"}, done_cyc,     v.exp_busy);
    chk({tag, " ab_load"},    ab_at_load,   0);
    chk({tag, " ab_done"},    ab_at_done,   v.exp_aborted);
    chk({tag, " step_done"},  step_at_done, 0);
    chk({tag, " rem_load"},   rem_load,     v.exp_rem_load);
    chk({tag, " rem_end"},    rem_end,      v.exp_rem_end);
    repeat (2) @(negedge clock);
  endtask

  // Check every output against its reset value
  task automatic chk_reset_outs(input string tag);
    chk({tag, " step"},    step,            0);
    chk({tag, " dir"},     dir,             0);
    chk({tag, " busy"},    busy,            0);
    chk({tag, " done"},    done,            0);
    chk({tag, " aborted"}, aborted,         0);
    chk({tag, " ack"},     cmd_ack,         0);
    chk({tag, " rem"},     steps_remaining, 0);
  endtask

  initial begin
    int   acks, dones, ack2_cyc, done1_cyc, done2_cyc, dir_chg, last_chg;
    int   rem12, rem29, busy11, reset_dones, idle_bad;
    logic prev_dir;

    //         word          ab_c acc stray busy pul fr dir abt rl re
    vecs[0] = '{32'h8000_0003,  0, 1'b0, 0, 26, 3, 2, 1'b1, 1'b0, 3, 0};
    vecs[1] = '{32'h0000_0000,  0, 1'b0, 0,  2, 0, 0, 1'b0, 1'b0, 0, 0};
    vecs[2] = '{32'h0000_0005, 11, 1'b0, 0, 12, 2, 2, 1'b0, 1'b1, 5, 4};
    vecs[3] = '{32'h0000_0007,  1, 1'b0, 0,  2, 0, 0, 1'b0, 1'b1, 7, 7};
    vecs[4] = '{32'h8000_0001,  0, 1'b1, 0, 10, 1, 2, 1'b1, 1'b0, 1, 0};
    vecs[5] = '{32'h8000_0002,  0, 1'b0, 5, 18, 2, 2, 1'b1, 1'b0, 2, 0};
    vecs[6] = '{32'h7FFF_0002,  0, 1'b0, 0, 18, 2, 2, 1'b0, 1'b0, 2, 0};

    // Reset state
    #2;
    chk_reset_outs("rst0");
    repeat (2) @(negedge clock);
    chk_reset_outs("rst1");
    ctrl_reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Back-to-back: cmd_valid held high across two commands
    acks = 0; dones = 0; ack2_cyc = 0; done1_cyc = 0; done2_cyc = 0;
    dir_chg = 0; last_chg = 0; rem12 = -1; rem29 = -1; busy11 = -1;
    prev_dir = dir;
    @(negedge clock);
    cmd_word  = 32'h8000_0001;
    cmd_valid = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clock);
      if (cmd_ack) begin
        acks++;
        if (acks == 1) cmd_word = 32'h0000_0002;
        if (acks == 2) begin
          ack2_cyc  = n;
          cmd_valid = 1'b0;
        end
      end
      if (done) begin
        dones++;
        if (dones == 1) done1_cyc = n;
        if (dones == 2) done2_cyc = n;
      end
      if (dir !== prev_dir) begin
        dir_chg++;
        last_chg = n;
      end
      prev_dir = dir;
      if (n == 11) busy11 = int'(busy);
      if (n == 12) rem12 = int'(steps_remaining);
      if (n == 29) rem29 = int'(steps_remaining);
    end
    cmd_valid = 1'b0;
    chk("b2b ack_count",  acks,      2);
    chk("b2b ack2_cycle", ack2_cyc,  12);
    chk("b2b done_count", dones,     2);
    chk("b2b done1",      done1_cyc, 10);
    chk("b2b done2",      done2_cyc, 29);
    chk("b2b dir_chg",    dir_chg,   2);
    chk("b2b dir_last",   last_chg,  12);
    chk("b2b idle_gap",   busy11,    0);
    chk("b2b rem_load2",  rem12,     2);
    chk("b2b rem_end2",   rem29,     0);

    // Asynchronous reset in the middle of the first LOW phase
    repeat (2) @(negedge clock);
    cmd_word  = 32'h0000_0003;
    cmd_valid = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clock);
      if (n == 1) cmd_valid = 1'b0;
    end
    chk("mid_low busy", busy, 1);
    chk("mid_low step", step, 0);
    #2 ctrl_reset = 1'b0;
    #1;
    chk_reset_outs("async");
    reset_dones = 0;
    repeat (2) begin
      @(negedge clock);
      if (done) reset_dones++;
    end
    ctrl_reset = 1'b1;
    idle_bad = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      if (done) reset_dones++;
      if (busy || step || cmd_ack) idle_bad++;
    end
    chk("reset no_done", reset_dones, 0);
    chk("reset idle",    idle_bad,    0);

    // Normal operation resumes after reset
    run_vec(vecs[1], 7);
    run_vec(vecs[0], 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
